// File: rtl/norm_engine.sv
// -----------------------------------------------------------------------------
// norm_engine : two-pass LayerNorm / RMSNorm engine on the shared activation SRAM.
//   Pass 1 streams x and accumulates sum and sum-of-squares. Pass 2 re-reads x,
//   fetches gamma and beta, normalises and writes saturated signed results.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_mode                   0 = LayerNorm, 1 = RMSNorm
//   cmd_len_log2               vector length N = 1 << cmd_len_log2
//   cmd_*_base                 src / dst / gamma / beta base addresses
//   sram_rd0_*                 x and gamma reads, data valid the cycle after en
//   sram_rd1_*                 beta reads, same latency
//   sram_wr_*                  normalised output writes
//   busy, done, err            status; done/err are single-cycle pulses
//
// rsqrt_lut : 256-entry reciprocal square root table, 1-cycle read latency.
//   data[a] = min(0xFFFF, 2^24 / floor(256*sqrt(a))), data[0] = 0xFFFF
//   i.e. 1/sqrt(a) as unsigned Q0.16.
// -----------------------------------------------------------------------------

module rsqrt_lut (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  addr,
    output logic [15:0] data
);
    function automatic logic [15:0] rsqrt_entry(input logic [7:0] a);
        logic [31:0] v;
        logic [31:0] r;
        logic [31:0] t;
        logic [31:0] q;
        v = {8'd0, a, 16'd0};
        r = 32'd0;
        // Bit-serial integer square root of a * 2^16.
        for (int b = 11; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (t * t <= v) begin
                r = t;
            end else begin
                r = r;
            end
        end
        if (a == 8'd0) begin
            rsqrt_entry = 16'hFFFF;
        end else begin
            q = 32'h0100_0000 / r;
            rsqrt_entry = (q > 32'h0000_FFFF) ? 16'hFFFF : q[15:0];
        end
    endfunction

    logic [15:0] rom_s [256];

    for (genvar g = 0; g < 256; g++) begin : g_rom
        assign rom_s[g] = rsqrt_entry(8'(g));
    end

    // Registered table read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= 16'd0;
        end else begin
            data <= rom_s[addr];
        end
    end
endmodule

module norm_engine #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int LOG2_MAX   = 10,
    parameter int ACC_W      = 32,
    parameter int EPS        = 1,
    parameter int VAR_SHIFT  = 8,
    parameter int GAMMA_FRAC = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [3:0]        cmd_len_log2,
    input  logic [ADDR_W-1:0] cmd_src_base,
    input  logic [ADDR_W-1:0] cmd_dst_base,
    input  logic [ADDR_W-1:0] cmd_gamma_base,
    input  logic [ADDR_W-1:0] cmd_beta_base,
    output logic              sram_rd0_en,
    output logic [ADDR_W-1:0] sram_rd0_addr,
    input  logic [DATA_W-1:0] sram_rd0_data,
    output logic              sram_rd1_en,
    output logic [ADDR_W-1:0] sram_rd1_addr,
    input  logic [DATA_W-1:0] sram_rd1_data,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // Wide signed working width: no intermediate can overflow before the clamp.
    localparam int SW = ACC_W + 16;
    localparam int IW = LOG2_MAX + 1;
    localparam logic [IW-1:0]       IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]   ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] OUT_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] OUT_MIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [SW-1:0]        LUT_TOP = {{(SW-8){1'b0}}, 8'hFF};

    typedef enum logic [3:0] {
        S_IDLE, S_P1_RD, S_P1_ACC, S_STAT, S_RSQ, S_RSQ_LAT,
        S_P2_RDX, S_P2_RDG, S_P2_WR, S_DONE
    } state_t;

    state_t                   state_r;
    logic [IW-1:0]            idx_r;
    logic                     mode_r;
    logic [3:0]               len_log2_r;
    logic [ADDR_W-1:0]        src_r, dst_r, gamma_base_r, beta_base_r;
    logic signed [ACC_W-1:0]  sum_r;
    logic [ACC_W-1:0]         sumsq_r;
    logic signed [SW-1:0]     mean_q8_r;
    logic [SW-1:0]            var_q8_r;
    logic [15:0]              inv_std_r;
    logic signed [DATA_W-1:0] x_r, beta_r;

    logic                       last_s;
    logic [ADDR_W-1:0]          idx_a_s, idx_n_s;
    logic signed [2*DATA_W-1:0] xw_s;
    logic [2*DATA_W-1:0]        sq_s;
    logic signed [SW-1:0]       sum_ext_s, mean_s, msq_s, diff_s;
    logic [SW-1:0]              e2_s, var_s, vpe_s;
    logic [7:0]                 lut_addr_s;
    logic [15:0]                lut_data_s;
    logic signed [SW-1:0]       c_s, prod_s, s_s, g_s, y_s, q_s;
    logic [DATA_W-1:0]          out_s;

    rsqrt_lut u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (lut_addr_s),
        .data  (lut_data_s)
    );

    // Index bookkeeping, pass-1 square and statistics from the accumulators.
    always_comb begin
        last_s    = (idx_r == ((IDX_ONE << len_log2_r) - IDX_ONE));
        idx_a_s   = ADDR_W'(idx_r);
        idx_n_s   = idx_a_s + ADDR_ONE;
        xw_s      = (2*DATA_W)'($signed(sram_rd0_data));
        sq_s      = xw_s * xw_s;
        sum_ext_s = SW'(sum_r);
        if (mode_r) begin
            mean_s = {SW{1'b0}};
        end else begin
            mean_s = (sum_ext_s <<< 4'd8) >>> len_log2_r;
        end
        e2_s   = (SW'(sumsq_r) << 4'd8) >> len_log2_r;
        msq_s  = (mean_s * mean_s) >>> 4'd8;
        diff_s = $signed(e2_s) - msq_s;
        if (mode_r) begin
            var_s = e2_s;
        end else if (diff_s[SW-1]) begin
            var_s = {SW{1'b0}};
        end else begin
            var_s = $unsigned(diff_s);
        end
        vpe_s      = (var_q8_r + SW'(EPS)) >> VAR_SHIFT;
        lut_addr_s = (vpe_s > LUT_TOP) ? 8'hFF : vpe_s[7:0];
    end

    // Pass-2 datapath: gamma arrives in P2_WR itself, so the result is formed
    // combinationally in that cycle and gated by the registered write enable.
    always_comb begin
        c_s    = (SW'(x_r) <<< 4'd8) - mean_q8_r;
        prod_s = c_s * $signed({{(SW-16){1'b0}}, inv_std_r});
        s_s    = prod_s >>> 5'd16;
        g_s    = (s_s * SW'($signed(sram_rd0_data))) >>> GAMMA_FRAC;
        y_s    = g_s + (SW'(beta_r) <<< 4'd8);
        q_s    = y_s >>> 4'd8;
        if (q_s > OUT_MAX) begin
            out_s = OUT_MAX[DATA_W-1:0];
        end else if (q_s < OUT_MIN) begin
            out_s = OUT_MIN[DATA_W-1:0];
        end else begin
            out_s = q_s[DATA_W-1:0];
        end
        if (sram_wr_en) begin
            sram_wr_data = out_s;
        end else begin
            sram_wr_data = {DATA_W{1'b0}};
        end
    end

    // Control FSM; SRAM strobes are registered on entry to the state that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;       idx_r <= {IW{1'b0}};
            mode_r <= 1'b0;          len_log2_r <= 4'd0;
            src_r <= {ADDR_W{1'b0}}; dst_r <= {ADDR_W{1'b0}};
            gamma_base_r <= {ADDR_W{1'b0}}; beta_base_r <= {ADDR_W{1'b0}};
            sum_r <= {ACC_W{1'b0}};  sumsq_r <= {ACC_W{1'b0}};
            mean_q8_r <= {SW{1'b0}}; var_q8_r <= {SW{1'b0}};
            inv_std_r <= 16'd0;      x_r <= {DATA_W{1'b0}}; beta_r <= {DATA_W{1'b0}};
            cmd_ready <= 1'b1;       busy <= 1'b0; done <= 1'b0; err <= 1'b0;
            sram_rd0_en <= 1'b0;     sram_rd0_addr <= {ADDR_W{1'b0}};
            sram_rd1_en <= 1'b0;     sram_rd1_addr <= {ADDR_W{1'b0}};
            sram_wr_en <= 1'b0;      sram_wr_addr <= {ADDR_W{1'b0}};
        end else begin
            done <= 1'b0;        err <= 1'b0;
            sram_rd0_en <= 1'b0; sram_rd0_addr <= {ADDR_W{1'b0}};
            sram_rd1_en <= 1'b0; sram_rd1_addr <= {ADDR_W{1'b0}};
            sram_wr_en <= 1'b0;  sram_wr_addr <= {ADDR_W{1'b0}};
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_r <= cmd_mode;         len_log2_r <= cmd_len_log2;
                        src_r <= cmd_src_base;      dst_r <= cmd_dst_base;
                        gamma_base_r <= cmd_gamma_base; beta_base_r <= cmd_beta_base;
                        idx_r <= {IW{1'b0}};
                        sum_r <= {ACC_W{1'b0}};     sumsq_r <= {ACC_W{1'b0}};
                        cmd_ready <= 1'b0;          busy <= 1'b1;
                        if (cmd_len_log2 > 4'(LOG2_MAX)) begin
                            state_r <= S_DONE; done <= 1'b1; err <= 1'b1;
                        end else begin
                            state_r <= S_P1_RD;
                            sram_rd0_en <= 1'b1; sram_rd0_addr <= cmd_src_base;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_P1_RD: state_r <= S_P1_ACC;
                S_P1_ACC: begin
                    sum_r   <= sum_r + ACC_W'($signed(sram_rd0_data));
                    sumsq_r <= sumsq_r + ACC_W'(sq_s);
                    if (last_s) begin
                        state_r <= S_STAT;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                        state_r <= S_P1_RD;
                        sram_rd0_en <= 1'b1; sram_rd0_addr <= src_r + idx_n_s;
                    end
                end
                S_STAT: begin
                    mean_q8_r <= mean_s; var_q8_r <= var_s;
                    idx_r <= {IW{1'b0}}; state_r <= S_RSQ;
                end
                S_RSQ: state_r <= S_RSQ_LAT;
                S_RSQ_LAT: begin
                    inv_std_r <= lut_data_s;
                    state_r <= S_P2_RDX;
                    sram_rd0_en <= 1'b1; sram_rd0_addr <= src_r;
                    sram_rd1_en <= 1'b1; sram_rd1_addr <= beta_base_r;
                end
                S_P2_RDX: begin
                    state_r <= S_P2_RDG;
                    sram_rd0_en <= 1'b1; sram_rd0_addr <= gamma_base_r + idx_a_s;
                end
                S_P2_RDG: begin
                    x_r <= sram_rd0_data; beta_r <= sram_rd1_data;
                    state_r <= S_P2_WR;
                    sram_wr_en <= 1'b1; sram_wr_addr <= dst_r + idx_a_s;
                end
                S_P2_WR: begin
                    if (last_s) begin
                        state_r <= S_DONE; done <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                        state_r <= S_P2_RDX;
                        sram_rd0_en <= 1'b1; sram_rd0_addr <= src_r + idx_n_s;
                        sram_rd1_en <= 1'b1; sram_rd1_addr <= beta_base_r + idx_n_s;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE; busy <= 1'b0; cmd_ready <= 1'b1;
                end
                default: begin
                    state_r <= S_IDLE; busy <= 1'b0; cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_norm_engine.sv
// -----------------------------------------------------------------------------
// tb_norm_engine : directed self-checking bench for norm_engine. A behavioural
// SRAM with 1-cycle read latency feeds the engine; a negedge monitor counts
// status pulses and logs every read and write address/data.
// -----------------------------------------------------------------------------
module tb_norm_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_mode;
    logic [3:0]  cmd_len_log2;
    logic [15:0] cmd_src_base, cmd_dst_base, cmd_gamma_base, cmd_beta_base;
    logic        sram_rd0_en, sram_rd1_en, sram_wr_en;
    logic [15:0] sram_rd0_addr, sram_rd1_addr, sram_wr_addr;
    logic [7:0]  sram_rd0_data = 8'd0, sram_rd1_data = 8'd0, sram_wr_data;
    logic        busy, done, err;

    always #5 clk = ~clk;

    norm_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_len_log2(cmd_len_log2), .cmd_src_base(cmd_src_base),
        .cmd_dst_base(cmd_dst_base), .cmd_gamma_base(cmd_gamma_base),
        .cmd_beta_base(cmd_beta_base),
        .sram_rd0_en(sram_rd0_en), .sram_rd0_addr(sram_rd0_addr), .sram_rd0_data(sram_rd0_data),
        .sram_rd1_en(sram_rd1_en), .sram_rd1_addr(sram_rd1_addr), .sram_rd1_data(sram_rd1_data),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
        .busy(busy), .done(done), .err(err)
    );

    logic [7:0] mem [0:65535];

    // SRAM read ports with one cycle of latency.
    always @(posedge clk) begin
        if (sram_rd0_en) sram_rd0_data <= mem[sram_rd0_addr];
        if (sram_rd1_en) sram_rd1_data <= mem[sram_rd1_addr];
    end

    int n_busy = 0, n_done = 0, n_err = 0, n_rd0 = 0, n_rd1 = 0, n_wr = 0;
    int rd0_log [0:2047];
    int wr_addr_log [0:2047];
    int wr_data_log [0:2047];

    // Monitor: sample outputs on the falling edge.
    always @(negedge clk) begin
        if (busy) n_busy <= n_busy + 1;
        if (done) n_done <= n_done + 1;
        if (err)  n_err  <= n_err + 1;
        if (sram_rd1_en) n_rd1 <= n_rd1 + 1;
        if (sram_rd0_en) begin
            if (n_rd0 < 2048) rd0_log[n_rd0] <= int'(sram_rd0_addr);
            n_rd0 <= n_rd0 + 1;
        end
        if (sram_wr_en) begin
            if (n_wr < 2048) begin
                wr_addr_log[n_wr] <= int'(sram_wr_addr);
                wr_data_log[n_wr] <= int'($signed(sram_wr_data));
            end
            n_wr <= n_wr + 1;
        end
    end

    int n_cmp = 0, n_mis = 0;
    int b_busy, b_done, b_err, b_rd0, b_rd1, b_wr;
    int exp_q [$];

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] base, input int n, input int val);
        for (int i = 0; i < n; i++) mem[base + 16'(i)] = 8'(val);
    endtask

    task automatic check_writes(input string tag, input int base, input int n,
                                input logic [15:0] dst);
        for (int i = 0; i < n; i++) begin
            logic [15:0] ea;
            ea = dst + 16'(i);
            check_val($sformatf("%s_waddr%0d", tag, i), wr_addr_log[base+i], int'(ea));
            if (i < exp_q.size())
                check_val($sformatf("%s_wdata%0d", tag, i), wr_data_log[base+i], exp_q[i]);
        end
    endtask

    task automatic check_run(input string tag, input int n, input logic [15:0] dst);
        check_val({tag, "_nwr"}, n_wr - b_wr, n);
        check_writes(tag, b_wr, n, dst);
    endtask

    task automatic run_cmd(input logic mode, input logic [3:0] l2,
                           input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] gam, input logic [15:0] bet,
                           output int lat);
        int k;
        logic got;
        b_busy = n_busy; b_done = n_done; b_err = n_err;
        b_rd0 = n_rd0; b_rd1 = n_rd1; b_wr = n_wr;
        @(negedge clk);
        cmd_mode = mode; cmd_len_log2 = l2; cmd_src_base = src;
        cmd_dst_base = dst; cmd_gamma_base = gam; cmd_beta_base = bet;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        @(posedge clk); #1 cmd_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 6000) begin
            @(negedge clk); lat++;
            if (done) got = 1'b1;
        end
        check_val("done_seen", int'(got), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat, c, n_acc, n_dn, acc2, done1;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_len_log2 = 4'd0;
        cmd_src_base = 16'd0; cmd_dst_base = 16'd0; cmd_gamma_base = 16'd0; cmd_beta_base = 16'd0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", cmd_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_rd0", sram_rd0_en, 0);
        check_val("rst_rd1", sram_rd1_en, 0);
        check_val("rst_wr", sram_wr_en, 0);

        // 1: LayerNorm of a constant vector -> variance 0, output = beta.
        fill(16'h0100, 4, 5); fill(16'h0200, 4, 64);
        mem[16'h0300] = 8'sd1; mem[16'h0301] = -8'sd2; mem[16'h0302] = 8'sd3; mem[16'h0303] = 8'sd0;
        exp_q = '{1, -2, 3, 0};
        run_cmd(1'b0, 4'd2, 16'h0100, 16'h0400, 16'h0200, 16'h0300, lat);
        check_val("t1_lat", lat, 24);
        check_val("t1_busy", n_busy - b_busy, 24);
        check_val("t1_done", n_done - b_done, 1);
        check_val("t1_err", n_err - b_err, 0);
        check_val("t1_rd0", n_rd0 - b_rd0, 12);
        check_val("t1_rd1", n_rd1 - b_rd1, 4);
        check_run("t1", 4, 16'h0400);

        // 2: RMSNorm of zeros -> output = beta = 7.
        fill(16'h0700, 8, 64); fill(16'h0800, 8, 7);
        exp_q = '{7, 7, 7, 7, 7, 7, 7, 7};
        run_cmd(1'b1, 4'd3, 16'h0600, 16'h0900, 16'h0700, 16'h0800, lat);
        check_val("t2_busy", n_busy - b_busy, 44);
        check_val("t2_err", n_err - b_err, 0);
        check_val("t2_rd0", n_rd0 - b_rd0, 24);
        check_run("t2", 8, 16'h0900);

        // 3: RMSNorm of +100s with gamma=beta=127 -> positive clamp.
        fill(16'h1000, 16, 100); fill(16'h1100, 16, 127); fill(16'h1200, 16, 127);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(127);
        run_cmd(1'b1, 4'd4, 16'h1000, 16'h1300, 16'h1100, 16'h1200, lat);
        check_val("t3_busy", n_busy - b_busy, 84);
        check_run("t3", 16, 16'h1300);

        // 3b: LayerNorm x={0,8}: mean 4, var 16, inv_std 0.25 -> {-1,+1} + beta.
        mem[16'h1400] = 8'sd0; mem[16'h1401] = 8'sd8; fill(16'h1500, 2, 64);
        mem[16'h1600] = 8'sd10; mem[16'h1601] = -8'sd10;
        exp_q = '{9, -9};
        run_cmd(1'b0, 4'd1, 16'h1400, 16'h1700, 16'h1500, 16'h1600, lat);
        check_val("t3b_busy", n_busy - b_busy, 14);
        check_run("t3b", 2, 16'h1700);

        // 3c: RMSNorm of -100s with beta=-128 -> negative clamp.
        fill(16'h1800, 4, -100); fill(16'h1900, 4, 127); fill(16'h1A00, 4, -128);
        exp_q = '{-128, -128, -128, -128};
        run_cmd(1'b1, 4'd2, 16'h1800, 16'h1B00, 16'h1900, 16'h1A00, lat);
        check_run("t3c", 4, 16'h1B00);

        // 4: rejected length.
        run_cmd(1'b0, 4'd11, 16'h0100, 16'h2000, 16'h0200, 16'h0300, lat);
        check_val("t4_lat", lat, 1);
        check_val("t4_busy", n_busy - b_busy, 1);
        check_val("t4_done", n_done - b_done, 1);
        check_val("t4_err", n_err - b_err, 1);
        check_val("t4_rd0", n_rd0 - b_rd0, 0);
        check_val("t4_rd1", n_rd1 - b_rd1, 0);
        check_val("t4_wr", n_wr - b_wr, 0);
        check_val("t4_ready", cmd_ready, 1);

        // 5: address wrap on src and dst.
        fill(16'hFFFE, 2, 3); fill(16'h0000, 2, 3); fill(16'h2100, 4, 64);
        mem[16'h2200] = 8'sd4; mem[16'h2201] = 8'sd5; mem[16'h2202] = 8'sd6; mem[16'h2203] = 8'sd7;
        exp_q = '{4, 5, 6, 7};
        run_cmd(1'b0, 4'd2, 16'hFFFE, 16'hFFFD, 16'h2100, 16'h2200, lat);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] ea;
            ea = 16'hFFFE + 16'(i);
            check_val($sformatf("t5_p1rd%0d", i), rd0_log[b_rd0+i], int'(ea));
            check_val($sformatf("t5_p2rd%0d", i), rd0_log[b_rd0+4+2*i], int'(ea));
        end
        check_run("t5", 4, 16'hFFFD);

        // 6: reset during pass 2, then two commands with cmd_valid held high.
        b_wr = n_wr;
        @(negedge clk);
        cmd_mode = 1'b0; cmd_len_log2 = 4'd4; cmd_src_base = 16'h1000;
        cmd_dst_base = 16'h1C00; cmd_gamma_base = 16'h1100; cmd_beta_base = 16'h1200;
        cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        c = 0;
        while ((n_wr - b_wr) < 2 && c < 2000) begin @(negedge clk); c++; end
        rst_n = 1'b0;
        #1;
        check_val("t6_busy", busy, 0);
        check_val("t6_rd0", sram_rd0_en, 0);
        check_val("t6_rd1", sram_rd1_en, 0);
        check_val("t6_wr", sram_wr_en, 0);
        check_val("t6_done", done, 0);
        check_val("t6_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_rd0 = n_rd0; b_rd1 = n_rd1; b_wr = n_wr; b_done = n_done; b_err = n_err;
        repeat (3) @(negedge clk);
        check_val("t6_quiet", (n_rd0 - b_rd0) + (n_rd1 - b_rd1) + (n_wr - b_wr), 0);

        exp_q = '{1, -2, 3, 0};
        cmd_len_log2 = 4'd2; cmd_src_base = 16'h0100; cmd_dst_base = 16'h1D00;
        cmd_gamma_base = 16'h0200; cmd_beta_base = 16'h0300;
        cmd_valid = 1'b1;
        n_acc = 0; n_dn = 0; acc2 = -100; done1 = 0; c = 0;
        while (n_dn < 2 && c < 400) begin
            if (cmd_valid && cmd_ready) begin
                n_acc++;
                if (n_acc == 2) acc2 = c;
            end
            if (done) begin
                n_dn++;
                if (n_dn == 1) done1 = c;
            end
            if (n_acc == 2 && cmd_valid) begin
                @(posedge clk); #1 cmd_valid = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        if (done) n_dn++;
        repeat (3) @(negedge clk);
        check_val("t6_accepts", n_acc, 2);
        check_val("t6_dones", n_done - b_done, 2);
        check_val("t6_gap", acc2 - done1, 1);
        check_val("t6_err", n_err - b_err, 0);
        check_val("t6_nwr", n_wr - b_wr, 8);
        check_writes("t6a", b_wr, 4, 16'h1D00);
        check_writes("t6b", b_wr + 4, 4, 16'h1D00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
